// File: rtl/layer_out_serializer_pkg.sv
// Shared types and width helpers for the layer output serializer.
// Element widths come from the shared include.v macros; defaults below apply only when it is absent.
`ifndef dataWidth
`define dataWidth 16
`endif
`ifndef ROM_bitwidth
`define ROM_bitwidth 8
`endif

package layer_out_serializer_pkg;

    localparam int DATA_W = `dataWidth;
    localparam int ROM_W  = `ROM_bitwidth;
    localparam int OL_W   = 2 * DATA_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Sigmoid outputs are non-negative: zero-extend, or keep the low bits when narrowing.
    function automatic logic [DATA_W-1:0] widen(input logic [ROM_W-1:0] v);
        return DATA_W'(v);
    endfunction

endpackage

// File: rtl/layer_out_serializer_if.sv
// Bundle of the capture-side and stream-side signals around the serializer.
interface layer_out_serializer_if
    import layer_out_serializer_pkg::*;
#(
    parameter int numNeurons = 25
);
    logic [numNeurons-1:0]       x_valid;
    logic [numNeurons*ROM_W-1:0] x_in;
    logic                        out_ready;
    logic [DATA_W-1:0]           out_data;
    logic                        out_valid;
    logic                        out_last;
    logic [OL_W-1:0]             out_layer;
    logic                        busy;
    logic                        overrun;

    modport master (
        output x_valid, x_in, out_ready,
        input  out_data, out_valid, out_last, out_layer, busy, overrun
    );

    modport slave (
        input  x_valid, x_in, out_ready,
        output out_data, out_valid, out_last, out_layer, busy, overrun
    );
endinterface

// File: rtl/layer_out_serializer.sv
// Captures one layer's parallel neuron outputs and replays them as a ready/valid stream
// feeding the next layer, one element per accepted transfer.
module layer_out_serializer
    import layer_out_serializer_pkg::*;
#(
    parameter int numNeurons = 25,
    parameter int layerNo    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [numNeurons-1:0]       x_valid,
    input  logic [numNeurons*ROM_W-1:0] x_in,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_valid,
    output logic                        out_last,
    output logic [OL_W-1:0]             out_layer,
    output logic                        busy,
    output logic                        overrun
);

    localparam int CW = $clog2(numNeurons) + 1;
    localparam int IW = (numNeurons > 1) ? $clog2(numNeurons) : 1;
    localparam logic [CW-1:0] LAST = CW'(numNeurons - 1);

    state_e            r_state, w_next_state;
    logic [CW-1:0]     r_cnt, w_next_cnt;
    logic [DATA_W-1:0] r_buf [numNeurons];
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid, r_out_last, r_busy, r_overrun;
    logic              w_capture, w_fire, w_load, w_set_ovr;
    logic [IW-1:0]     w_next_idx;
    logic              w_unused_valid;

    // Only neuron 0 signals the capture; the other valid bits carry no extra information.
    assign w_capture      = x_valid[0];
    assign w_unused_valid = &x_valid;
    assign w_fire         = (r_state == SHIFT) && out_ready;
    assign w_next_idx     = w_next_cnt[IW-1:0];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_load       = 1'b0;
        w_set_ovr    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_capture) begin
                    w_load       = 1'b1;
                    w_next_cnt   = '0;
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (w_fire && r_cnt == LAST) begin
                    w_next_cnt = '0;
                    if (w_capture) w_load = 1'b1;
                    else           w_next_state = IDLE;
                end else begin
                    if (w_fire)    w_next_cnt = r_cnt + 1'b1;
                    if (w_capture) w_set_ovr  = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: the element buffer is never read before a capture writes it, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_load && !rst) begin
            for (int k = 0; k < numNeurons; k++) begin
                r_buf[k] <= widen(x_in[k*ROM_W +: ROM_W]);
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_out_valid <= (w_next_state == SHIFT);
            r_busy      <= (w_next_state == SHIFT);
            r_out_last  <= (w_next_state == SHIFT) && (w_next_cnt == LAST);
            r_overrun   <= r_overrun | w_set_ovr;
            // A fresh capture bypasses the buffer so element 0 appears on the very next cycle.
            if (w_load)
                r_out_data <= widen(x_in[0 +: ROM_W]);
            else if (w_next_state == SHIFT)
                r_out_data <= r_buf[w_next_idx];
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign overrun   = r_overrun;
    assign out_layer = OL_W'(layerNo + 1);

endmodule

// File: tb/tb_layer_out_serializer.sv
// Directed bench for layer_out_serializer with four 8-bit neurons: table-driven streams
// plus hand-written reset and width sequences.
module tb_layer_out_serializer;
    import layer_out_serializer_pkg::*;

    localparam int N = 4;

    typedef struct {
        logic [N-1:0]       xv;
        logic               rdy;
        logic [N*ROM_W-1:0] xin;
        logic               ev;
        logic [DATA_W-1:0]  ed;
        logic               el;
        logic               eb;
        logic               eo;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[$];

    layer_out_serializer_if #(.numNeurons(N)) bus ();

    layer_out_serializer #(.numNeurons(N), .layerNo(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .x_valid   (bus.x_valid),
        .x_in      (bus.x_in),
        .out_ready (bus.out_ready),
        .out_data  (bus.out_data),
        .out_valid (bus.out_valid),
        .out_last  (bus.out_last),
        .out_layer (bus.out_layer),
        .busy      (bus.busy),
        .overrun   (bus.overrun)
    );

    always #5 clk = ~clk;

    localparam logic [N*ROM_W-1:0] A = 32'h4433_2211;
    localparam logic [N*ROM_W-1:0] B = 32'h8877_6655;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [N-1:0] xv, input logic rdy, input logic [N*ROM_W-1:0] xin,
                                input logic ev, input logic [DATA_W-1:0] ed, input logic el,
                                input logic eo);
        vec_t v;
        v.xv = xv; v.rdy = rdy; v.xin = xin;
        v.ev = ev; v.ed = ed; v.el = el; v.eb = ev; v.eo = eo;
        return v;
    endfunction

    task automatic check_idle(input string tag, input logic exp_ovr);
        check({tag, ".valid"},   bus.out_valid, 1'b0);
        check({tag, ".busy"},    bus.busy,      1'b0);
        check({tag, ".last"},    bus.out_last,  1'b0);
        check({tag, ".overrun"}, bus.overrun,   exp_ovr);
    endtask

    initial begin
        rst = 1'b1;
        bus.x_valid = '0;
        bus.x_in = A;
        bus.out_ready = 1'b1;

        // Single burst, free-running ready; upper valid bits alone must not start a burst.
        tbl.push_back(mk(4'b0001, 1, A, 1, 16'h0011, 0, 0));
        tbl.push_back(mk(4'b0000, 1, A, 1, 16'h0022, 0, 0));
        tbl.push_back(mk(4'b0000, 1, A, 1, 16'h0033, 0, 0));
        tbl.push_back(mk(4'b0000, 1, A, 1, 16'h0044, 1, 0));
        tbl.push_back(mk(4'b0000, 1, A, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(4'b1110, 1, A, 0, 16'h0000, 0, 0));
        // Toggling ready: 7 cycles from first valid to last transfer.
        tbl.push_back(mk(4'b0001, 1, A, 1, 16'h0011, 0, 0));
        tbl.push_back(mk(4'b0000, 1, A, 1, 16'h0022, 0, 0));
        tbl.push_back(mk(4'b0000, 0, A, 1, 16'h0022, 0, 0));
        tbl.push_back(mk(4'b0000, 1, A, 1, 16'h0033, 0, 0));
        tbl.push_back(mk(4'b0000, 0, A, 1, 16'h0033, 0, 0));
        tbl.push_back(mk(4'b0000, 1, A, 1, 16'h0044, 1, 0));
        tbl.push_back(mk(4'b0000, 0, A, 1, 16'h0044, 1, 0));
        tbl.push_back(mk(4'b0000, 1, A, 0, 16'h0000, 0, 0));
        // Second capture on the final transfer: eight back-to-back elements.
        tbl.push_back(mk(4'b0001, 1, A, 1, 16'h0011, 0, 0));
        tbl.push_back(mk(4'b0000, 1, A, 1, 16'h0022, 0, 0));
        tbl.push_back(mk(4'b0000, 1, A, 1, 16'h0033, 0, 0));
        tbl.push_back(mk(4'b0000, 1, A, 1, 16'h0044, 1, 0));
        tbl.push_back(mk(4'b0001, 1, B, 1, 16'h0055, 0, 0));
        tbl.push_back(mk(4'b0000, 1, B, 1, 16'h0066, 0, 0));
        tbl.push_back(mk(4'b0000, 1, B, 1, 16'h0077, 0, 0));
        tbl.push_back(mk(4'b0000, 1, B, 1, 16'h0088, 1, 0));
        tbl.push_back(mk(4'b0000, 1, B, 0, 16'h0000, 0, 0));
        // Capture during element 1 is dropped and flags a sticky overrun.
        tbl.push_back(mk(4'b0001, 1, A, 1, 16'h0011, 0, 0));
        tbl.push_back(mk(4'b0000, 1, A, 1, 16'h0022, 0, 0));
        tbl.push_back(mk(4'b0001, 1, B, 1, 16'h0033, 0, 1));
        tbl.push_back(mk(4'b0000, 1, B, 1, 16'h0044, 1, 1));
        tbl.push_back(mk(4'b0000, 1, B, 0, 16'h0000, 0, 1));
        tbl.push_back(mk(4'b0000, 1, B, 0, 16'h0000, 0, 1));

        step();
        step();
        rst = 1'b0;
        check_idle("reset", 1'b0);
        check("reset.data",  bus.out_data,  '0);
        check("out_layer",   bus.out_layer, 33'd2);

        for (int i = 0; i < tbl.size(); i++) begin
            bus.x_valid   = tbl[i].xv;
            bus.x_in      = tbl[i].xin;
            bus.out_ready = tbl[i].rdy;
            step();
            check($sformatf("v%0d.valid", i),   bus.out_valid, tbl[i].ev);
            check($sformatf("v%0d.busy", i),    bus.busy,      tbl[i].eb);
            check($sformatf("v%0d.last", i),    bus.out_last,  tbl[i].el);
            check($sformatf("v%0d.overrun", i), bus.overrun,   tbl[i].eo);
            if (tbl[i].ev)
                check($sformatf("v%0d.data", i), bus.out_data, tbl[i].ed);
        end

        // Reset mid-burst at element 2, with a capture attempted in the reset cycle.
        bus.x_valid = 4'b0001; bus.x_in = A; bus.out_ready = 1'b1;
        step();
        bus.x_valid = 4'b0000;
        check("rb.e0", bus.out_data, 16'h0011);
        step();
        step();
        check("rb.e2", bus.out_data, 16'h0033);
        check("rb.ovr_before", bus.overrun, 1'b1);
        rst = 1'b1; bus.x_valid = 4'b0001;
        step();
        rst = 1'b0; bus.x_valid = 4'b0000;
        check_idle("rb.after_rst", 1'b0);
        check("rb.data_rst", bus.out_data, '0);
        step();
        check_idle("rb.no_resume", 1'b0);

        // All-ones narrow element is zero-extended; restart begins at element 0.
        bus.x_valid = 4'b0001; bus.x_in = 32'h4433_22FF;
        step();
        bus.x_valid = 4'b0000;
        check("wide.valid", bus.out_valid, 1'b1);
        check("wide.data",  bus.out_data,  16'h00FF);
        step();
        check("wide.e1",    bus.out_data,  16'h0022);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_out_serializer.md
LAYER_OUT_SERIALIZER -- requirements
Module: layer_out_serializer

Interface
REQ-001 SHALL have parameter numNeurons, default 25, number of neuron outputs captured per layer.
REQ-002 SHALL have parameter layerNo, default 1, layer index reported on out_layer.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port x_valid, input, numNeurons, per-neuron outvalid bits.
REQ-006 SHALL have port x_in, input, numNeurons*`ROM_bitwidth, neuron k output at bits [k*`ROM_bitwidth +: `ROM_bitwidth].
REQ-007 SHALL have port out_ready, input, 1, downstream accept; tie high for free-running neurons.
REQ-008 SHALL have port out_data, output, `dataWidth, serialized element (next-layer myinput).
REQ-009 SHALL have port out_valid, output, 1, out_data valid (next-layer myinputValid).
REQ-010 SHALL have port out_last, output, 1, high with the final element (index numNeurons-1).
REQ-011 SHALL have port out_layer, output, 2*`dataWidth+1, constant layerNo+1 (next-layer config_layer_num).
REQ-012 SHALL have port busy, output, 1, high while in SHIFT.
REQ-013 SHALL have port overrun, output, 1, sticky error flag.

Function
REQ-014 SHALL implement FSM with states IDLE and SHIFT.
REQ-015 SHALL treat capture event as x_valid[0]; x_valid bits other than bit 0 SHALL be ignored for control.
REQ-016 In IDLE, on capture event, SHALL register all of x_in into buffer, clear index cnt to 0, enter SHIFT.
REQ-017 In SHIFT, SHALL drive out_valid=1 and out_data=buffer[cnt]; out_last=1 iff cnt==numNeurons-1.
REQ-018 Latency: capture at edge t SHALL yield out_valid with element 0 in cycle t+1.
REQ-019 Transfer occurs when out_valid & out_ready; on transfer cnt SHALL increment; non-transfer cycles SHALL hold out_data, cnt stable.
REQ-020 On transfer with cnt==numNeurons-1, SHALL return to IDLE and clear cnt to 0.
REQ-021 Capture event in SHIFT coinciding with the final transfer SHALL be accepted: reload buffer, cnt=0, remain in SHIFT, no bubble.
REQ-022 Capture event in SHIFT at any other cycle SHALL be discarded and SHALL set overrun; buffer contents unchanged.
REQ-023 overrun SHALL stay set until rst.
REQ-024 Width rule: each element SHALL be zero-extended from `ROM_bitwidth to `dataWidth (sigmoid outputs non-negative); if `ROM_bitwidth > `dataWidth, the low `dataWidth bits SHALL be taken.
REQ-025 cnt SHALL be $clog2(numNeurons)+1 bits wide; numNeurons=1 SHALL work (out_last with element 0).
REQ-026 All outputs SHALL be registered; out_layer combinational constant.

Reset
REQ-027 rst SHALL force state IDLE, cnt=0, out_valid=0, out_last=0, busy=0, overrun=0, out_data=0.
REQ-028 rst asserted mid-SHIFT SHALL abort the burst; no further out_valid until next capture after rst deasserts.
REQ-029 Capture event in the rst cycle SHALL be ignored.
REQ-030 Buffer contents need not be reset.

Structure
REQ-031 `dataWidth, `ROM_bitwidth SHALL come from the shared include.v; no new macros.
REQ-032 SHALL be a single flat module; no sub-module.

Verification
REQ-033 numNeurons=4, x_in elements {0x11,0x22,0x33,0x44}, out_ready=1, one-cycle capture -> out_valid 4 consecutive cycles starting next cycle, data 0x11..0x44, out_last on 0x44 only, then busy=0.
REQ-034 Same capture, out_ready toggling 1,0,1,0,... -> each element held until accepted, order preserved, 7 cycles from first valid to last transfer.
REQ-035 Second capture {0x55,0x66,0x77,0x88} at the final-transfer cycle -> 8 back-to-back elements, no bubble, overrun=0.
REQ-036 Second capture during element index 1 -> stream continues 0x11..0x44 unchanged, overrun=1 and stays 1 until rst.
REQ-037 rst pulse while cnt==2 -> next cycle out_valid=0, overrun=0, busy=0; subsequent capture restarts at element 0.
REQ-038 `ROM_bitwidth<`dataWidth, element all-ones -> out_data upper bits zero.
